// File: rtl/inv_mix_iter_if.sv
// Handshake bundle for the inverse nibble-mixing layer: input block channel
// and output block channel, each valid/ready with a 16*NCOL-bit payload.
interface inv_mix_iter_if #(
    parameter int unsigned NCOL = 4
);
    localparam int unsigned DW = 16 * NCOL;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // Producer of input blocks / consumer of output blocks
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The unmixing block itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/inv_mix_iter.sv
// Iterative inverse column mix for the decrypt round: captures one block,
// unmixes one 16-bit column per clock, then holds the result until taken.
module inv_mix_iter #(
    parameter int unsigned NCOL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    inv_mix_iter_if.slave     bus
);
    localparam int unsigned DW = 16 * NCOL;
    localparam int unsigned CW = (NCOL > 1) ? $clog2(NCOL) : 1;

    // Reject an empty state at elaboration time
    if (NCOL < 1) begin : g_ncol_check
        $error("inv_mix_iter: NCOL must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Inverse of C0=N3^N2, C1=N0, C2=N0^N1, C3=N2 on one 16-bit column
    function automatic logic [15:0] inv_col(input logic [15:0] c);
        logic [3:0] c0, c1, c2, c3;
        c0 = c[3:0];
        c1 = c[7:4];
        c2 = c[11:8];
        c3 = c[15:12];
        return {c0 ^ c3, c3, c2 ^ c1, c1};
    endfunction

    // State, block and column-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: capture in IDLE, unmix column cnt in BUSY, hold in DONE
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        cnt_d   = cnt_q;

        if (clr) begin
            state_d = S_IDLE;
            st_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        st_d    = bus.in_data;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    for (int unsigned k = 0; k < NCOL; k++) begin
                        if (cnt_q == CW'(k)) begin
                            st_d[16*k +: 16] = inv_col(st_q[16*k +: 16]);
                        end
                    end
                    if (cnt_q == CW'(NCOL - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    st_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the registered state
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = st_q;

endmodule

// File: tb/tb_inv_mix_iter.sv
// Directed bench for inv_mix_iter (NCOL=4): latency, column math, DONE hold,
// async reset mid-block, synchronous clear, and a randomized round-trip run.
module tb_inv_mix_iter;
    localparam int unsigned NCOL = 4;
    localparam int unsigned DW   = 16 * NCOL;

    logic clk;
    logic rst;
    logic clr;

    int errors;
    int checks;

    inv_mix_iter_if #(.NCOL(NCOL)) bus ();

    inv_mix_iter #(.NCOL(NCOL)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one block and let it be taken on the next edge
    task automatic send(input logic [DW-1:0] d);
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) step();
        chk("in_ready_wait", DW'(bus.in_ready), DW'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Encrypt-side mix, used to close the loop on unmixed output
    function automatic logic [DW-1:0] fwd_mix(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        logic [15:0]   n;
        r = '0;
        for (int k = 0; k < int'(NCOL); k++) begin
            n = s[16*k +: 16];
            r[16*k +: 16] = {n[11:8], n[3:0] ^ n[7:4], n[3:0], n[15:12] ^ n[11:8]};
        end
        return r;
    endfunction

    logic [DW-1:0] held;
    logic [DW-1:0] rd;
    int            handshakes;
    logic          got;

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_in_ready",  DW'(bus.in_ready),  DW'(1));
        chk("rst_out_data",  bus.out_data,       '0);
        #4 rst = 1'b0;
        step();

        // T1: latency and basic column math
        bus.out_ready = 1'b1;
        send(64'h2743_2743_2743_2743);
        chk("t1_busy_in_ready", DW'(bus.in_ready), DW'(0));
        step();
        chk("t1_col0_done", bus.out_data, 64'h2743_2743_2743_1234);
        chk("t1_e1_valid", DW'(bus.out_valid), DW'(0));
        step();
        chk("t1_e2_valid", DW'(bus.out_valid), DW'(0));
        step();
        chk("t1_e3_valid", DW'(bus.out_valid), DW'(0));
        step();
        chk("t1_e4_valid", DW'(bus.out_valid), DW'(1));
        chk("t1_data",     bus.out_data, 64'h1234_1234_1234_1234);
        chk("t1_done_in_ready", DW'(bus.in_ready), DW'(0));
        step();
        chk("t1_idle_valid", DW'(bus.out_valid), DW'(0));
        chk("t1_idle_ready", DW'(bus.in_ready),  DW'(1));

        // T2: one-hot nibble per column
        bus.out_ready = 1'b0;
        send(64'h1000_0100_0010_0001);
        repeat (4) step();
        chk("t2_valid", DW'(bus.out_valid), DW'(1));
        chk("t2_data",  bus.out_data, 64'h1100_0010_0011_1000);

        // T3: backpressure in DONE with input chatter
        held = bus.out_data;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = {$urandom, $urandom};
            step();
            chk("t3_valid",    DW'(bus.out_valid), DW'(1));
            chk("t3_data",     bus.out_data, held);
            chk("t3_in_ready", DW'(bus.in_ready), DW'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("t3_release", DW'(bus.in_ready), DW'(1));
        chk("t3_no_capture", bus.out_data, held);

        // T4: asynchronous reset with cnt==2
        send(64'hAAAA_5555_0F0F_F0F0);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("t4_out_valid", DW'(bus.out_valid), DW'(0));
        chk("t4_out_data",  bus.out_data, '0);
        chk("t4_in_ready",  DW'(bus.in_ready), DW'(1));
        rst = 1'b0;
        send(64'h2743_2743_2743_2743);
        repeat (4) step();
        chk("t4_after_valid", DW'(bus.out_valid), DW'(1));
        chk("t4_after_data",  bus.out_data, 64'h1234_1234_1234_1234);
        step();

        // T5: synchronous clear beats handshake and capture in DONE
        bus.out_ready = 1'b0;
        send(64'h0001_0002_0004_0008);
        repeat (4) step();
        chk("t5_done", DW'(bus.out_valid), DW'(1));
        clr           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        chk("t5_valid", DW'(bus.out_valid), DW'(0));
        chk("t5_ready", DW'(bus.in_ready),  DW'(1));
        chk("t5_data",  bus.out_data, '0);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("t5_stay_idle", DW'(bus.in_ready), DW'(1));
        chk("t5_stay_zero", bus.out_data, '0);

        // T6: random blocks, random backpressure, forward mix must recover input
        handshakes = 0;
        for (int b = 0; b < 1000; b++) begin
            rd = {$urandom, $urandom};
            send(rd);
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid === 1'b1 && bus.out_ready) begin
                    chk("t6_roundtrip", fwd_mix(bus.out_data), rd);
                    handshakes++;
                    got = 1'b1;
                end
                step();
            end
            chk("t6_block_done", DW'(got), DW'(1));
        end
        bus.out_ready = 1'b0;
        chk("t6_handshakes", DW'(handshakes), DW'(1000));
        repeat (3) step();
        chk("t6_no_extra", DW'(bus.out_valid), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
